mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
Multi-cycle sequencer that lets the RV32 core share one single-ported, variable-latency memory for instruction fetch and data load/store. Each instruction runs in order: fetch, decode/execute, optional data access, commit. The sequencer owns the memory handshake, holds the fetched instruction and the loaded data stable in registers, and gates architectural state updates through commit_en. It sits between the core's instruction/data memory ports and the external memory.

Parameters:
TIMEOUT_CYCLES, 256, max wait cycles for mem_ready per transaction before a bus error; must be >= 1
RETIRE_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
pc  input  32  core instruction address (ProgramCounter output)
core_should_read_mem  input  1  decoded load request, valid in S_EXEC
core_should_write_mem  input  1  decoded store request, valid in S_EXEC
core_data_addr  input  32  load/store address (ALU result), valid in S_EXEC
core_write_data  input  32  store data, valid in S_EXEC
instr  output  32  registered fetched instruction fed to the core
mem_read_data  output  32  registered load data fed to the register write mux
commit_en  output  1  one-cycle strobe; PC and register files may update only when high
mem_req  output  1  memory request valid
mem_we  output  1  1 = write, 0 = read
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_ready  input  1  memory completes the request this cycle
mem_rdata  input  32  memory read data, valid when mem_req & mem_ready
bus_error  output  1  sticky; a timeout or an illegal request occurred
halted  output  1  sequencer is in S_HALT
retired_count  output  RETIRE_W  number of committed instructions, wraps modulo 2^RETIRE_W

Behaviour:
- Reset takes effect at the posedge while reset=1. All registers clear: state=S_FETCH, instr=0x00000013 (NOP), mem_read_data=0, bus_error=0, retired_count=0, wait_cnt=0.
- Outputs are decoded from registered state and registered request fields. During reset and in the cycle after it: commit_en=0, mem_req=0, halted=0.
- States: S_FETCH, S_EXEC, S_DATA, S_COMMIT, S_HALT.
- S_FETCH: mem_req=1, mem_we=0, mem_addr=pc.
  - If mem_ready: capture mem_rdata into instr, go to S_EXEC.
- S_EXEC: exactly 1 cycle, mem_req=0. Core datapath settles on the new instr. Core request fields are latched into addr_q, wdata_q and we_q.
  - If read or write is requested, go to S_DATA; otherwise go to S_COMMIT.
  - If read and write are both set: the write wins, bus_error is set, and the access proceeds as a write.
- S_DATA: mem_req=1, mem_we=we_q, mem_addr=addr_q, mem_wdata=wdata_q.
  - If mem_ready: go to S_COMMIT. On a read, also capture mem_rdata into mem_read_data.
- S_COMMIT: commit_en=1 for exactly 1 cycle, retired_count increments, then go to S_FETCH.
- Request fields (mem_addr, mem_we, mem_wdata) stay stable while mem_req=1 and mem_ready=0. mem_req drops in the cycle after completion.
- mem_addr and mem_wdata read as 0 when mem_req=0; mem_we reads 0 when mem_req=0.
- Latency with mem_ready tied high: 3 cycles per instruction without a data access (FETCH, EXEC, COMMIT), 4 cycles with one. Each wait cycle adds 1.
- Timeout: wait_cnt clears on entering S_FETCH or S_DATA and increments each cycle mem_req=1 and mem_ready=0.
  - When wait_cnt reaches TIMEOUT_CYCLES and mem_ready=0: set bus_error and go to S_HALT; the transaction is abandoned.
  - If mem_ready=1 arrives in that same cycle, completion wins and there is no error.
- S_HALT: mem_req=0, commit_en=0, halted=1. The only exit is reset.
- Reset mid-transaction: the request is abandoned and mem_req=0 in the next cycle. No commit is issued. Loaded data is not preserved.
- mem_read_data keeps its last captured value across stores and non-memory instructions.
- retired_count wraps from all-ones to 0 without flagging.

Test Plan:
- ALU-only program, mem_ready=1 constantly, instr=0x00500093 at pc=0 -> mem_req high for 1 cycle, instr=0x00500093 from the 2nd cycle, commit_en pulses every 3rd cycle, retired_count=1 after the first commit.
- Load, addr 0x100, mem_rdata=0xDEADBEEF, mem_ready held low 2 cycles in S_DATA -> mem_addr=0x100 and mem_we=0 stable for 3 cycles, mem_read_data=0xDEADBEEF in the S_COMMIT cycle, instruction takes 6 cycles.
- Store, addr 0x200, wdata 0x12345678 -> one S_DATA cycle with mem_we=1, mem_addr=0x200, mem_wdata=0x12345678; mem_read_data unchanged; commit_en the following cycle.
- TIMEOUT_CYCLES=4, mem_ready never asserted on a fetch -> bus_error=1 and halted=1 after 4 wait cycles, mem_req=0 thereafter, no commit_en; reset returns to S_FETCH with bus_error=0.
- Reset asserted in the 2nd wait cycle of a load -> mem_req=0 and commit_en=0 the next cycle, retired_count=0, fetch restarts at the current pc.
- Read and write both set in S_EXEC -> write issued, bus_error=1, instruction still commits; separately, with RETIRE_W=4, 16 commits wrap retired_count to 0.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Multi-cycle fetch/execute/data/commit sequencer that shares one variable-latency,
// single-ported memory between instruction fetch and data load/store for an RV32 core.
module mem_access_sequencer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int RETIRE_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc,
  input  logic                core_should_read_mem,
  input  logic                core_should_write_mem,
  input  logic [31:0]         core_data_addr,
  input  logic [31:0]         core_write_data,
  output logic [31:0]         instr,
  output logic [31:0]         mem_read_data,
  output logic                commit_en,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ready,
  input  logic [31:0]         mem_rdata,
  output logic                bus_error,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired_count
);

  localparam int          WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_DATA   = 3'd2,
    S_COMMIT = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                bus_error_q, bus_error_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;

  logic              waiting;
  logic [WAIT_W-1:0] wait_inc;
  logic              timeout_hit;
  logic              any_access;

  // req_q is the registered request valid: it lags the state by design so that
  // the cycle right after reset never presents a request to the memory.
  assign waiting     = req_q && !mem_ready;
  assign wait_inc    = wait_cnt_q + WAIT_W'(1);
  assign timeout_hit = waiting && (wait_inc == WAIT_W'(TIMEOUT_CYCLES));
  assign any_access  = core_should_read_mem || core_should_write_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (req_q && mem_ready) state_d = S_EXEC;
        else if (timeout_hit)   state_d = S_HALT;
      end
      S_EXEC:   state_d = any_access ? S_DATA : S_COMMIT;
      S_DATA: begin
        if (req_q && mem_ready) state_d = S_COMMIT;
        else if (timeout_hit)   state_d = S_HALT;
      end
      S_COMMIT: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
    req_d = (state_d == S_FETCH) || (state_d == S_DATA);
  end

  always_comb begin
    commit_en = (state_q == S_COMMIT);
    halted    = (state_q == S_HALT);
    mem_req   = req_q;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (req_q && state_q == S_FETCH) begin
      mem_addr = pc;
    end else if (req_q && state_q == S_DATA) begin
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
  end

  // Architectural side: captured words, latched request fields, error and retire bookkeeping.
  always_comb begin
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    bus_error_d = bus_error_q || timeout_hit;
    retired_d   = retired_q;
    wait_cnt_d  = waiting ? wait_inc : '0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    if (state_q == S_FETCH && req_q && mem_ready) begin
      instr_d = mem_rdata;
    end
    if (state_q == S_EXEC) begin
      addr_d  = core_data_addr;
      wdata_d = core_write_data;
      we_d    = core_should_write_mem;
      if (core_should_read_mem && core_should_write_mem) bus_error_d = 1'b1;
    end
    if (state_q == S_DATA && req_q && mem_ready && !we_q) begin
      rdata_d = mem_rdata;
    end
    if (state_q == S_COMMIT) begin
      retired_d = retired_q + RETIRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q     <= NOP;
      rdata_q     <= 32'h0;
      bus_error_q <= 1'b0;
      retired_q   <= '0;
      wait_cnt_q  <= '0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
      bus_error_q <= bus_error_d;
      retired_q   <= retired_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
    end
  end

  assign instr         = instr_q;
  assign mem_read_data = rdata_q;
  assign bus_error     = bus_error_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer (TIMEOUT_CYCLES=4, RETIRE_W=4).
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        rd, wr;
  logic [31:0] daddr, wdata_in;
  logic [31:0] instr, mem_read_data;
  logic        commit_en, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_error, halted;
  logic [3:0]  retired_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_access_sequencer #(.TIMEOUT_CYCLES(4), .RETIRE_W(4)) u_dut (
    .clk(clk), .reset(reset), .pc(pc),
    .core_should_read_mem(rd), .core_should_write_mem(wr),
    .core_data_addr(daddr), .core_write_data(wdata_in),
    .instr(instr), .mem_read_data(mem_read_data), .commit_en(commit_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_error(bus_error), .halted(halted), .retired_count(retired_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after the first post-reset edge (state FETCH, no request yet).
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rst_mem_req: got %0h want 0", mem_req); end
    nvec++; if (commit_en !== 1'b0) begin nerr++; $display("FAIL rst_commit: got %0h want 0", commit_en); end
    nvec++; if (halted !== 1'b0) begin nerr++; $display("FAIL rst_halted: got %0h want 0", halted); end
    nvec++; if (bus_error !== 1'b0) begin nerr++; $display("FAIL rst_bus_error: got %0h want 0", bus_error); end
    nvec++; if (retired_count !== 4'd0) begin nerr++; $display("FAIL rst_retired: got %0h want 0", retired_count); end
    nvec++; if (instr !== 32'h0000_0013) begin nerr++; $display("FAIL rst_instr: got %08h want 00000013", instr); end
    nvec++; if (mem_read_data !== 32'h0) begin nerr++; $display("FAIL rst_rdata: got %08h want 0", mem_read_data); end
    reset = 1'b0;
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rst_after_req: got %0h want 0", mem_req); end
    nvec++; if (mem_addr !== 32'h0) begin nerr++; $display("FAIL rst_after_addr: got %08h want 0", mem_addr); end
  endtask

  task automatic test_alu();
    pc = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    do_reset();
    tick();
    nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL alu_fetch_req: got %0h want 1", mem_req); end
    nvec++; if (mem_we !== 1'b0) begin nerr++; $display("FAIL alu_fetch_we: got %0h want 0", mem_we); end
    nvec++; if (instr !== 32'h0000_0013) begin nerr++; $display("FAIL alu_instr_pre: got %08h want 00000013", instr); end
    tick();
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL alu_exec_req: got %0h want 0", mem_req); end
    nvec++; if (instr !== 32'h0050_0093) begin nerr++; $display("FAIL alu_instr: got %08h want 00500093", instr); end
    nvec++; if (commit_en !== 1'b0) begin nerr++; $display("FAIL alu_exec_commit: got %0h want 0", commit_en); end
    tick();
    nvec++; if (commit_en !== 1'b1) begin nerr++; $display("FAIL alu_commit1: got %0h want 1", commit_en); end
    nvec++; if (retired_count !== 4'd0) begin nerr++; $display("FAIL alu_ret_pre: got %0h want 0", retired_count); end
    tick();
    nvec++; if (retired_count !== 4'd1) begin nerr++; $display("FAIL alu_ret1: got %0h want 1", retired_count); end
    nvec++; if (commit_en !== 1'b0) begin nerr++; $display("FAIL alu_fetch2_commit: got %0h want 0", commit_en); end
    nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL alu_fetch2_req: got %0h want 1", mem_req); end
    tick();
    tick();
    nvec++; if (commit_en !== 1'b1) begin nerr++; $display("FAIL alu_commit2: got %0h want 1", commit_en); end
  endtask

  task automatic test_load();
    pc = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h0000_2083;
    do_reset();
    tick();
    nvec++; if (mem_addr !== 32'h40) begin nerr++; $display("FAIL ld_fetch_addr: got %08h want 00000040", mem_addr); end
    tick();
    rd = 1'b1; daddr = 32'h100; mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL ld_exec_req: got %0h want 0", mem_req); end
    for (int c = 0; c < 3; c++) begin
      tick();
      rd = 1'b0; daddr = 32'h0;
      if (c == 2) mem_ready = 1'b1;
      nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL ld_data_req[%0d]: got %0h want 1", c, mem_req); end
      nvec++; if (mem_addr !== 32'h100) begin nerr++; $display("FAIL ld_data_addr[%0d]: got %08h want 00000100", c, mem_addr); end
      nvec++; if (mem_we !== 1'b0) begin nerr++; $display("FAIL ld_data_we[%0d]: got %0h want 0", c, mem_we); end
      nvec++; if (mem_read_data !== 32'h0) begin nerr++; $display("FAIL ld_rdata_pre[%0d]: got %08h want 0", c, mem_read_data); end
    end
    tick();
    nvec++; if (commit_en !== 1'b1) begin nerr++; $display("FAIL ld_commit: got %0h want 1", commit_en); end
    nvec++; if (mem_read_data !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL ld_rdata: got %08h want deadbeef", mem_read_data); end
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL ld_commit_req: got %0h want 0", mem_req); end
  endtask

  // Runs straight after test_load, so mem_read_data starts at 0xDEADBEEF and retired_count at 0.
  task automatic test_store();
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0020_A023;
    nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL st_fetch_req: got %0h want 1", mem_req); end
    nvec++; if (retired_count !== 4'd1) begin nerr++; $display("FAIL st_ret_pre: got %0h want 1", retired_count); end
    tick();
    wr = 1'b1; daddr = 32'h200; wdata_in = 32'h1234_5678;
    tick();
    wr = 1'b0; daddr = 32'h0; wdata_in = 32'h0;
    nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL st_data_req: got %0h want 1", mem_req); end
    nvec++; if (mem_we !== 1'b1) begin nerr++; $display("FAIL st_data_we: got %0h want 1", mem_we); end
    nvec++; if (mem_addr !== 32'h200) begin nerr++; $display("FAIL st_data_addr: got %08h want 00000200", mem_addr); end
    nvec++; if (mem_wdata !== 32'h1234_5678) begin nerr++; $display("FAIL st_data_wdata: got %08h want 12345678", mem_wdata); end
    tick();
    nvec++; if (commit_en !== 1'b1) begin nerr++; $display("FAIL st_commit: got %0h want 1", commit_en); end
    nvec++; if (mem_read_data !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL st_rdata_kept: got %08h want deadbeef", mem_read_data); end
    nvec++; if (mem_wdata !== 32'h0) begin nerr++; $display("FAIL st_idle_wdata: got %08h want 0", mem_wdata); end
    nvec++; if (mem_we !== 1'b0) begin nerr++; $display("FAIL st_idle_we: got %0h want 0", mem_we); end
    tick();
    nvec++; if (retired_count !== 4'd2) begin nerr++; $display("FAIL st_ret: got %0h want 2", retired_count); end
  endtask

  task automatic test_timeout();
    pc = 32'h8; mem_ready = 1'b0; mem_rdata = 32'h0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      nvec++; if (mem_req !== 1'b1 || halted !== 1'b0 || bus_error !== 1'b0) begin
        nerr++; $display("FAIL to_wait[%0d]: got req=%0h halt=%0h err=%0h want 1/0/0", c, mem_req, halted, bus_error);
      end
    end
    tick();
    nvec++; if (halted !== 1'b1) begin nerr++; $display("FAIL to_halted: got %0h want 1", halted); end
    nvec++; if (bus_error !== 1'b1) begin nerr++; $display("FAIL to_bus_error: got %0h want 1", bus_error); end
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      nvec++; if (mem_req !== 1'b0 || commit_en !== 1'b0 || halted !== 1'b1) begin
        nerr++; $display("FAIL to_stay[%0d]: got req=%0h commit=%0h halt=%0h want 0/0/1", c, mem_req, commit_en, halted);
      end
      tick();
    end
    do_reset();
    nvec++; if (bus_error !== 1'b0 || halted !== 1'b0) begin nerr++; $display("FAIL to_reset: got err=%0h halt=%0h want 0/0", bus_error, halted); end
    tick();
    nvec++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin nerr++; $display("FAIL to_refetch: got req=%0h addr=%08h want 1/00000008", mem_req, mem_addr); end
  endtask

  task automatic test_reset_mid_load();
    pc = 32'h80; mem_ready = 1'b1; mem_rdata = 32'h0000_2083;
    do_reset();
    tick();
    tick();
    rd = 1'b1; daddr = 32'h100; mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    tick();
    rd = 1'b0;
    tick();
    nvec++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin nerr++; $display("FAIL rm_wait2: got req=%0h addr=%08h want 1/00000100", mem_req, mem_addr); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rm_req: got %0h want 0", mem_req); end
    nvec++; if (commit_en !== 1'b0) begin nerr++; $display("FAIL rm_commit: got %0h want 0", commit_en); end
    nvec++; if (retired_count !== 4'd0) begin nerr++; $display("FAIL rm_retired: got %0h want 0", retired_count); end
    nvec++; if (mem_read_data !== 32'h0) begin nerr++; $display("FAIL rm_rdata: got %08h want 0", mem_read_data); end
    tick();
    nvec++; if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0) begin
      nerr++; $display("FAIL rm_refetch: got req=%0h addr=%08h we=%0h want 1/00000080/0", mem_req, mem_addr, mem_we);
    end
  endtask

  task automatic test_rw_conflict();
    pc = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    do_reset();
    tick();
    tick();
    rd = 1'b1; wr = 1'b1; daddr = 32'h300; wdata_in = 32'hCAFE_F00D; mem_rdata = 32'h5555_AAAA;
    nvec++; if (bus_error !== 1'b0) begin nerr++; $display("FAIL rw_err_pre: got %0h want 0", bus_error); end
    tick();
    rd = 1'b0; wr = 1'b0;
    nvec++; if (mem_we !== 1'b1) begin nerr++; $display("FAIL rw_we: got %0h want 1", mem_we); end
    nvec++; if (mem_addr !== 32'h300) begin nerr++; $display("FAIL rw_addr: got %08h want 00000300", mem_addr); end
    nvec++; if (mem_wdata !== 32'hCAFE_F00D) begin nerr++; $display("FAIL rw_wdata: got %08h want cafef00d", mem_wdata); end
    nvec++; if (bus_error !== 1'b1) begin nerr++; $display("FAIL rw_err: got %0h want 1", bus_error); end
    tick();
    nvec++; if (commit_en !== 1'b1) begin nerr++; $display("FAIL rw_commit: got %0h want 1", commit_en); end
    nvec++; if (mem_read_data !== 32'h0) begin nerr++; $display("FAIL rw_rdata: got %08h want 0", mem_read_data); end
    tick();
    nvec++; if (retired_count !== 4'd1 || bus_error !== 1'b1) begin nerr++; $display("FAIL rw_after: got ret=%0h err=%0h want 1/1", retired_count, bus_error); end
  endtask

  task automatic test_wrap();
    int ncommit;
    ncommit = 0;
    pc = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      tick();
      if (commit_en === 1'b1) ncommit++;
    end
    nvec++; if (ncommit != 16) begin nerr++; $display("FAIL wrap_commits: got %0d want 16", ncommit); end
    nvec++; if (retired_count !== 4'd15) begin nerr++; $display("FAIL wrap_ret15: got %0h want f", retired_count); end
    tick();
    nvec++; if (retired_count !== 4'd0) begin nerr++; $display("FAIL wrap_ret0: got %0h want 0", retired_count); end
    nvec++; if (bus_error !== 1'b0) begin nerr++; $display("FAIL wrap_err: got %0h want 0", bus_error); end
  endtask

  initial begin
    reset = 1'b1; pc = 32'h0; rd = 1'b0; wr = 1'b0; daddr = 32'h0; wdata_in = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid_load();
    test_rw_conflict();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
